// File: rtl/neosd_pkg.sv
// Shared types and constants for the NEOSD command-line sequencer.
// Holds response modes, sequencer states, frame lengths and the CRC7 polynomial.
package neosd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_SHORT = 2'd1,
    RESP_LONG  = 2'd2
  } resp_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    WAIT,
    RX,
    GAP
  } cmd_state_t;

  localparam int         CMD_FRAME_BITS  = 48;
  localparam int         LONG_FRAME_BITS = 136;
  localparam logic [6:0] CRC7_POLY       = 7'h09;

  // The reserved encoding 3 behaves like "no response".
  function automatic resp_mode_t decode_rmode(input logic [1:0] mode);
    case (mode)
      2'd1:    return RESP_SHORT;
      2'd2:    return RESP_LONG;
      default: return RESP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enabled cycle, MSB first.
// Shared between command transmit and response receive, which never overlap.
module neosd_crc7
  import neosd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       dat_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic       fb;

  assign fb    = dat_i ^ crc_q[6];
  assign crc_o = crc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/neosd_cmd_ctrl.sv
// SD CMD-line sequencer: sends a 48-bit command with CRC7, receives and checks
// a short/long response with timeout, then holds the line idle for the NCC gap.
module neosd_cmd_ctrl
  import neosd_pkg::*;
#(
  parameter int RESP_TIMEOUT = 64,
  parameter int GAP_CYCLES   = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         tx_stb_i,
  input  logic         rx_stb_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [5:0]   req_idx_i,
  input  logic [31:0]  req_arg_i,
  input  logic [1:0]   req_rmode_i,
  input  logic         req_crc_chk_i,
  input  logic         abort_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe_o,
  input  logic         sd_cmd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [5:0]   resp_idx_o,
  output logic [127:0] resp_o,
  output logic         err_timeout_o,
  output logic         err_crc_o,
  output logic         err_frame_o
);

  localparam int             TW          = $clog2(RESP_TIMEOUT + 1);
  localparam int             GW          = $clog2(GAP_CYCLES + 1);
  localparam logic [7:0]     TX_LEN      = 8'(CMD_FRAME_BITS);
  localparam logic [7:0]     TX_CRC_BITS = 8'(CMD_FRAME_BITS - 8);
  localparam logic [7:0]     LONG_LEN    = 8'(LONG_FRAME_BITS);
  localparam logic [TW-1:0]  TOUT_LAST   = TW'(RESP_TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST    = GW'(GAP_CYCLES - 1);

  cmd_state_t   state_q;
  resp_mode_t   rmode_q;
  logic         crc_chk_q;
  logic [47:0]  tx_sh_q;
  logic [7:0]   bit_cnt_q;
  logic [TW-1:0] tout_q;
  logic [GW-1:0] gap_q;
  logic [126:0] rx_sh_q;
  logic         rx_tbit_q;
  logic         cmd_q, oe_q, done_q;
  logic         err_to_q, err_crc_q, err_frame_q;
  logic [127:0] resp_q;
  logic [5:0]   idx_q;

  logic         accept, rx_last, rx_crc_win;
  logic         crc_clr, crc_en, crc_din;
  logic [6:0]   crc;
  logic [47:0]  tx_word;
  logic [127:0] rx_frame;
  logic [7:0]   rx_len;

  assign accept   = req_valid_i && (state_q == IDLE);
  // Once the 40 header/argument bits are out, splice the CRC in ahead of the end bit.
  assign tx_word  = (bit_cnt_q == TX_CRC_BITS) ? {crc, tx_sh_q[40:0]} : tx_sh_q;
  assign rx_len   = (rmode_q == RESP_LONG) ? LONG_LEN : TX_LEN;
  assign rx_last  = (bit_cnt_q + 8'd1) == rx_len;
  assign rx_frame = {rx_sh_q, sd_cmd_i};
  // bit_cnt_q is the number of bits already received: short covers frame bits
  // 46..8, long covers 127..8 (the 8-bit R2 header is excluded).
  assign rx_crc_win = (rmode_q == RESP_LONG) ? (bit_cnt_q >= 8'd8 && bit_cnt_q <= 8'd127)
                                             : (bit_cnt_q >= 8'd1 && bit_cnt_q <= 8'd39);
  assign crc_clr  = accept || (state_q == TX && tx_stb_i && bit_cnt_q == TX_LEN);
  assign crc_en   = (state_q == TX && tx_stb_i && bit_cnt_q < TX_CRC_BITS) ||
                    (state_q == RX && rx_stb_i && rx_crc_win);
  assign crc_din  = (state_q == TX) ? tx_sh_q[47] : sd_cmd_i;

  neosd_crc7 u_crc7 (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .dat_i  (crc_din),
    .crc_o  (crc)
  );

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign sd_cmd_o      = cmd_q;
  assign sd_cmd_oe_o   = oe_q;
  assign done_o        = done_q;
  assign resp_idx_o    = idx_q;
  assign resp_o        = resp_q;
  assign err_timeout_o = err_to_q;
  assign err_crc_o     = err_crc_q;
  assign err_frame_o   = err_frame_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      rmode_q     <= RESP_NONE;
      crc_chk_q   <= 1'b0;
      tx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      tout_q      <= '0;
      gap_q       <= '0;
      rx_sh_q     <= '0;
      rx_tbit_q   <= 1'b0;
      cmd_q       <= 1'b1;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_crc_q   <= 1'b0;
      err_frame_q <= 1'b0;
      resp_q      <= '0;
      idx_q       <= '0;
    end else begin
      done_q <= 1'b0;
      // Abort outranks any strobe arriving in the same cycle.
      if (abort_i && state_q != IDLE) begin
        state_q <= GAP;
        oe_q    <= 1'b0;
        cmd_q   <= 1'b1;
        gap_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (req_valid_i) begin
            rmode_q     <= decode_rmode(req_rmode_i);
            crc_chk_q   <= req_crc_chk_i;
            tx_sh_q     <= {2'b01, req_idx_i, req_arg_i, 7'd0, 1'b1};
            bit_cnt_q   <= '0;
            resp_q      <= '0;
            err_to_q    <= 1'b0;
            err_crc_q   <= 1'b0;
            err_frame_q <= 1'b0;
            state_q     <= TX;
          end
          TX: if (tx_stb_i) begin
            if (bit_cnt_q == TX_LEN) begin
              oe_q      <= 1'b0;
              cmd_q     <= 1'b1;
              bit_cnt_q <= '0;
              tout_q    <= '0;
              if (rmode_q == RESP_NONE) begin
                done_q  <= 1'b1;
                state_q <= GAP;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              oe_q      <= 1'b1;
              cmd_q     <= tx_word[47];
              tx_sh_q   <= {tx_word[46:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
          end
          WAIT: if (rx_stb_i) begin
            if (!sd_cmd_i) begin
              bit_cnt_q <= 8'd1;
              rx_sh_q   <= '0;
              state_q   <= RX;
            end else if (tout_q == TOUT_LAST) begin
              err_to_q <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= GAP;
            end else begin
              tout_q <= tout_q + 1'b1;
            end
          end
          RX: if (rx_stb_i) begin
            rx_sh_q   <= rx_frame[126:0];
            bit_cnt_q <= bit_cnt_q + 8'd1;
            if (bit_cnt_q == 8'd1) rx_tbit_q <= sd_cmd_i;
            if (rx_last) begin
              if (rmode_q == RESP_LONG) begin
                resp_q <= rx_frame;
              end else begin
                resp_q <= {96'd0, rx_frame[39:8]};
                idx_q  <= rx_frame[45:40];
              end
              err_crc_q   <= crc_chk_q && (crc != rx_frame[7:1]);
              err_frame_q <= rx_tbit_q || !sd_cmd_i;
              done_q      <= 1'b1;
              state_q     <= GAP;
            end
          end
          GAP: if (tx_stb_i) begin
            if (gap_q == GAP_LAST) begin
              gap_q   <= '0;
              state_q <= IDLE;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
